// File: rtl/cpu_io_pkg.sv
// Shared types and default parameters for the CPU board-side I/O blocks.
package cpu_io_pkg;

  typedef enum logic {
    IDLE,
    PENDING
  } in_state_t;

  localparam int N_DATA          = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/sync_debounce.sv
// Per-bit synchroniser chain followed by a whole-vector debouncer: the vector
// is accepted only after it has held steady for DEBOUNCE_CYCLES cycles.
module sync_debounce #(
  parameter int W               = cpu_io_pkg::N_DATA + 1,
  parameter int SYNC_STAGES     = cpu_io_pkg::SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = cpu_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_sw_raw,
  output logic [W-1:0] o_sw_stable
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0]                  w_s;
  logic [W-1:0]                  r_cand;
  logic [CNT_W-1:0]              r_cnt;
  logic [W-1:0]                  r_stable;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Any change restarts the count; the counter then saturates and keeps
  // re-loading the same accepted value until the next change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else if (w_s != r_cand) begin
      r_cand <= w_s;
      r_cnt  <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_stable <= r_cand;
    end
  end

  assign o_sw_stable = r_stable;

endmodule

// File: rtl/switch_input_port.sv
// Switch receiver for the CPU input instruction: debounced switches, one
// capture per enter press, held under a valid/ack handshake.
module switch_input_port #(
  parameter int n               = cpu_io_pkg::N_DATA,
  parameter int SYNC_STAGES     = cpu_io_pkg::SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = cpu_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [n:0]          sw_raw,
  input  logic                in_ack,
  output logic signed [n-1:0] sw_data,
  output logic                in_valid,
  output logic                overrun,
  output logic [n:0]          sw_stable
);

  import cpu_io_pkg::in_state_t;
  import cpu_io_pkg::IDLE;
  import cpu_io_pkg::PENDING;

  logic [n:0]   w_stable;
  logic         r_enter_q;
  logic         w_enter_rise;
  in_state_t    r_state;
  in_state_t    w_next_state;
  logic [n-1:0] r_data;
  logic [n-1:0] w_data_next;
  logic         r_valid;
  logic         w_valid_next;
  logic         r_overrun;
  logic         w_overrun_next;

  sync_debounce #(
    .W               (n + 1),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk         (clk),
    .reset       (reset),
    .i_sw_raw    (sw_raw),
    .o_sw_stable (w_stable)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enter_q <= 1'b0;
    end else begin
      r_enter_q <= w_stable[n];
    end
  end

  assign w_enter_rise = w_stable[n] & ~r_enter_q;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_data_next    = r_data;
    w_valid_next   = r_valid;
    w_overrun_next = r_overrun;
    unique case (r_state)
      IDLE: begin
        if (w_enter_rise) begin
          w_data_next  = w_stable[n-1:0];
          w_valid_next = 1'b1;
          w_next_state = PENDING;
        end
      end
      PENDING: begin
        if (in_ack) begin
          w_overrun_next = 1'b0;
          if (w_enter_rise) begin
            w_data_next = w_stable[n-1:0];
          end else begin
            w_valid_next = 1'b0;
            w_next_state = IDLE;
          end
        end else if (w_enter_rise) begin
          // The new press is dropped; the unconsumed value wins.
          w_overrun_next = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_overrun <= w_overrun_next;
    end
  end

  assign sw_data   = r_data;
  assign in_valid  = r_valid;
  assign overrun   = r_overrun;
  assign sw_stable = w_stable;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port; captured values are checked by a
// handshake monitor against a queue of expected {data, overrun} pairs.
module tb_switch_input_port;

  import cpu_io_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [8:0]        sw_raw;
  logic              in_ack;
  logic signed [7:0] sw_data;
  logic              in_valid;
  logic              overrun;
  logic [8:0]        sw_stable;

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  switch_input_port #(
    .n               (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .in_ack    (in_ack),
    .sw_data   (sw_data),
    .in_valid  (in_valid),
    .overrun   (overrun),
    .sw_stable (sw_stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic enter, input logic [7:0] d);
    sw_raw = {enter, d};
    repeat (10) tick();
  endtask

  task automatic ack_once();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
  endtask

  // Monitor: every accepted handshake consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_valid && in_ack) begin
        if (expq.size() == 0) begin
          check("sb_unexpected_capture", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("sb_data", {24'd0, $unsigned(sw_data)}, {24'd0, e.data});
          check("sb_overrun", {31'd0, overrun}, {31'd0, e.ovr});
        end
      end
    end
  end

  initial begin
    int glitch_bad;

    // Reset with random switches: nothing may leak through.
    reset  = 1'b1;
    in_ack = 1'b0;
    sw_raw = 9'($urandom);
    repeat (3) tick();
    check("rst_sw_data", {24'd0, $unsigned(sw_data)}, 32'd0);
    check("rst_in_valid", {31'd0, in_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_sw_stable", {23'd0, sw_stable}, 32'd0);
    check("rst_state", {31'd0, dut.r_state}, {31'd0, IDLE});
    reset = 1'b0;

    // Press 45: enter reaches sw_stable on edge 7, capture on edge 8.
    settle(1'b0, 8'd45);
    sw_raw = {1'b1, 8'd45};
    expq.push_back('{data: 8'd45, ovr: 1'b0});
    repeat (6) tick();
    check("press_stable_e6", {31'd0, sw_stable[8]}, 32'd0);
    tick();
    check("press_stable_e7", {31'd0, sw_stable[8]}, 32'd1);
    check("press_valid_e7", {31'd0, in_valid}, 32'd0);
    tick();
    check("press_valid_e8", {31'd0, in_valid}, 32'd1);
    check("press_data_e8", {24'd0, $unsigned(sw_data)}, 32'd45);
    ack_once();
    check("press_ack_clears", {31'd0, in_valid}, 32'd0);

    // Two-cycle glitch on data bit 3 with enter low.
    settle(1'b0, 8'd45);
    check("glitch_pre_stable", {23'd0, sw_stable}, {23'd0, 9'd45});
    glitch_bad = 0;
    sw_raw = {1'b0, 8'd45 ^ 8'h08};
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 1) sw_raw = {1'b0, 8'd45};
      if (sw_stable !== 9'd45 || in_valid !== 1'b0) glitch_bad++;
    end
    check("glitch_filtered", glitch_bad, 32'd0);

    // Overrun: -12 pending, a second press of 17 is dropped.
    settle(1'b0, 8'hF4);
    expq.push_back('{data: 8'hF4, ovr: 1'b1});
    sw_raw = {1'b1, 8'hF4};
    repeat (8) tick();
    check("ovr_first_valid", {31'd0, in_valid}, 32'd1);
    check("ovr_first_data", {24'd0, $unsigned(sw_data)}, 32'hF4);
    settle(1'b0, 8'hF4);
    settle(1'b0, 8'd17);
    sw_raw = {1'b1, 8'd17};
    repeat (8) tick();
    check("ovr_data_kept", {24'd0, $unsigned(sw_data)}, 32'hF4);
    check("ovr_flag_set", {31'd0, overrun}, 32'd1);
    check("ovr_still_valid", {31'd0, in_valid}, 32'd1);
    ack_once();
    check("ovr_ack_valid", {31'd0, in_valid}, 32'd0);
    check("ovr_ack_flag", {31'd0, overrun}, 32'd0);

    // Ack coinciding with a new capture of 4.
    settle(1'b0, 8'd9);
    expq.push_back('{data: 8'd9, ovr: 1'b0});
    sw_raw = {1'b1, 8'd9};
    repeat (8) tick();
    check("sim_first_valid", {31'd0, in_valid}, 32'd1);
    settle(1'b0, 8'd9);
    settle(1'b0, 8'd4);
    expq.push_back('{data: 8'd4, ovr: 1'b0});
    sw_raw = {1'b1, 8'd4};
    repeat (7) tick();
    ack_once();
    check("sim_valid_kept", {31'd0, in_valid}, 32'd1);
    check("sim_new_data", {24'd0, $unsigned(sw_data)}, 32'd4);
    check("sim_overrun_clear", {31'd0, overrun}, 32'd0);
    ack_once();
    check("sim_final_ack", {31'd0, in_valid}, 32'd0);

    // Enter held for 50 cycles while data bits churn: a single capture.
    settle(1'b0, 8'h21);
    expq.push_back('{data: 8'h21, ovr: 1'b0});
    sw_raw = {1'b1, 8'h21};
    repeat (8) tick();
    check("held_capture", {24'd0, $unsigned(sw_data)}, 32'h21);
    for (int i = 0; i < 50; i++) begin
      sw_raw = {1'b1, 8'(i * 37)};
      tick();
    end
    sw_raw = {1'b1, 8'h5A};
    repeat (10) tick();
    check("held_data_kept", {24'd0, $unsigned(sw_data)}, 32'h21);
    check("held_no_overrun", {31'd0, overrun}, 32'd0);
    check("held_valid", {31'd0, in_valid}, 32'd1);

    // Reset while pending drops the value at once; enter still held recaptures.
    reset = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, in_valid}, 32'd0);
    check("rst_async_state", {31'd0, dut.r_state}, {31'd0, IDLE});
    expq.delete();
    repeat (2) tick();
    reset = 1'b0;
    expq.push_back('{data: 8'h5A, ovr: 1'b0});
    repeat (7) tick();
    check("recap_valid_e7", {31'd0, in_valid}, 32'd0);
    check("recap_stable_e7", {31'd0, sw_stable[8]}, 32'd1);
    tick();
    check("recap_valid_e8", {31'd0, in_valid}, 32'd1);
    check("recap_data_e8", {24'd0, $unsigned(sw_data)}, 32'h5A);
    ack_once();
    check("recap_ack", {31'd0, in_valid}, 32'd0);
    repeat (2) tick();
    check("sb_queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
